// File: rtl/rom_stream_writer_pkg.sv
// ---------------------------------------------------------------------------
// rom_stream_writer_pkg
//   Shared types and constants for the ROM stream writer.
//   - state_t         : top-level load FSM states
//   - word_t          : one FIFO entry (24-bit byte address + 16-bit data)
//   - HDR_*_OFS       : cartridge header field offsets relative to HDR_BASE
//   - MASK_BASE       : size code 0 corresponds to a 1 KiB region
//   - size_to_mask()  : size code -> address mask, truncated to 24 bits
// ---------------------------------------------------------------------------
package rom_stream_writer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int WORD_W = 40;

  typedef struct packed {
    logic [23:0] addr;
    logic [15:0] data;
  } word_t;

  localparam logic [23:0] HDR_MAP_CTRL_OFS = 24'h000015;
  localparam logic [23:0] HDR_ROM_SIZE_OFS = 24'h000017;
  localparam logic [23:0] HDR_RAM_SIZE_OFS = 24'h000018;
  localparam logic [23:0] MASK_BASE        = 24'h000400;

  // Large size codes shift the base out of the 24-bit field, so the mask
  // saturates to all ones after the subtraction wraps.
  function automatic logic [23:0] size_to_mask(input logic [7:0] size);
    logic [23:0] shifted;
    shifted = MASK_BASE << size;
    return shifted - 24'd1;
  endfunction

endpackage

// File: rtl/rom_stream_writer_fifo.sv
// ---------------------------------------------------------------------------
// rom_word_fifo
//   Small first-word-fall-through FIFO of 40-bit {addr, data} words.
//   A push is accepted while full only if a pop happens in the same cycle,
//   in which case occupancy is unchanged.
// Ports:
//   wclk, reset      : clock, asynchronous active-high reset
//   push, wdata      : write request and word
//   pop              : consume head (ignored when empty)
//   rdata            : current head word (valid when !empty)
//   full, empty      : occupancy flags
// ---------------------------------------------------------------------------
module rom_word_fifo
  import rom_stream_writer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              wclk,
  input  logic              reset,
  input  logic              push,
  input  logic [WORD_W-1:0] wdata,
  input  logic              pop,
  output logic [WORD_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level;
  logic              do_push;
  logic              do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  // When full, the pop frees the slot the push lands in (wr_ptr == rd_ptr).
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge wclk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge wclk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/rom_stream_writer.sv
// ---------------------------------------------------------------------------
// rom_stream_writer
//   Packs a byte stream from a ROM loader into 16-bit words, buffers them in
//   a small word FIFO and writes them to memory with a req/ack handshake.
//   Also captures the cartridge header fields (map control, ROM and RAM size)
//   as they stream past and derives address masks from the size codes.
// Ports:
//   wclk, reset                 : clock, asynchronous active-high reset
//   din, din_valid, src_loading : byte stream from the loader (no back-pressure)
//   mem_addr, mem_din, mem_req  : word write request (held until mem_ack)
//   mem_ack                     : one-cycle write acknowledge
//   map_ctrl, rom_size          : captured header fields
//   rom_mask, ram_mask          : masks derived from the size codes
//   loading, done, overflow     : status
// ---------------------------------------------------------------------------
module rom_stream_writer
  import rom_stream_writer_pkg::*;
#(
  parameter logic [23:0] HDR_BASE   = 24'h007FC0,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        wclk,
  input  logic        reset,
  input  logic [7:0]  din,
  input  logic        din_valid,
  input  logic        src_loading,
  output logic [23:0] mem_addr,
  output logic [15:0] mem_din,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [7:0]  map_ctrl,
  output logic [3:0]  rom_size,
  output logic [23:0] rom_mask,
  output logic [23:0] ram_mask,
  output logic        loading,
  output logic        done,
  output logic        overflow
);

  localparam logic [23:0] MAP_CTRL_ADDR = HDR_BASE + HDR_MAP_CTRL_OFS;
  localparam logic [23:0] ROM_SIZE_ADDR = HDR_BASE + HDR_ROM_SIZE_OFS;
  localparam logic [23:0] RAM_SIZE_ADDR = HDR_BASE + HDR_RAM_SIZE_OFS;

  state_t      state;
  logic [23:0] count;
  logic [7:0]  low_byte;
  logic        pending;
  logic [7:0]  ram_size;

  logic        byte_in;
  logic        odd_byte;
  logic        pad_push;
  logic        push;
  logic        pop;
  word_t       push_word;
  word_t       head;
  logic        fifo_full;
  logic        fifo_empty;

  // Bytes are accepted in every state but DONE.
  assign byte_in  = din_valid && (state != DONE);
  assign odd_byte = byte_in && count[0];
  // A dangling even byte is padded out once streaming has stopped.
  assign pad_push = (state == FLUSH) && pending && !din_valid;
  assign push     = odd_byte || pad_push;
  assign pop      = !mem_req && !fifo_empty;

  // In both push cases the pending low byte sits at count-1 (count is odd).
  always_comb begin
    push_word.addr = count - 24'd1;
    push_word.data = odd_byte ? {din, low_byte} : {8'h00, low_byte};
  end

  rom_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .wclk  (wclk),
    .reset (reset),
    .push  (push),
    .wdata (push_word),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Byte packing and header capture.
  always_ff @(posedge wclk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      low_byte <= '0;
      pending  <= 1'b0;
      map_ctrl <= '0;
      rom_size <= '0;
      ram_size <= '0;
    end else begin
      if (byte_in) begin
        count <= count + 24'd1;
        if (!count[0]) begin
          low_byte <= din;
          pending  <= 1'b1;
        end else begin
          pending  <= 1'b0;
        end
        if (count == MAP_CTRL_ADDR) map_ctrl <= din;
        if (count == ROM_SIZE_ADDR) rom_size <= din[3:0];
        if (count == RAM_SIZE_ADDR) ram_size <= din;
      end else if (pad_push) begin
        pending <= 1'b0;
      end
    end
  end

  // Masks follow the captured size codes one cycle later.
  always_ff @(posedge wclk or posedge reset) begin
    if (reset) begin
      rom_mask <= 24'h0003FF;
      ram_mask <= 24'h0003FF;
    end else begin
      rom_mask <= size_to_mask({4'h0, rom_size});
      ram_mask <= size_to_mask(ram_size);
    end
  end

  // Sticky: a word was lost because the FIFO had no room.
  always_ff @(posedge wclk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

  // Memory writer: one outstanding request; the next pop can only happen
  // once mem_req has been seen low, i.e. the cycle after the acknowledge.
  always_ff @(posedge wclk or posedge reset) begin
    if (reset) begin
      mem_req  <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
    end else if (pop) begin
      mem_req  <= 1'b1;
      mem_addr <= head.addr;
      mem_din  <= head.data;
    end else if (mem_req && mem_ack) begin
      mem_req  <= 1'b0;
    end
  end

  // Load FSM with registered status outputs.
  always_ff @(posedge wclk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      loading <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (din_valid || src_loading) begin
            state   <= LOAD;
            loading <= 1'b1;
          end
        end
        LOAD: begin
          if (!src_loading) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          // No push can happen in the finishing cycle, so overflow is final.
          if (fifo_empty && !pending && !mem_req && !push && !din_valid) begin
            state   <= DONE;
            loading <= 1'b0;
            done    <= !overflow;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state   <= IDLE;
          loading <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_stream_writer.sv
// ---------------------------------------------------------------------------
// tb_rom_stream_writer
//   Self-checking bench for rom_stream_writer. HDR_BASE is moved close to the
//   start of the stream so header captures are reachable in a few hundred
//   cycles; all header positions are expressed relative to it.
// ---------------------------------------------------------------------------
module tb_rom_stream_writer;

  localparam logic [23:0] HDR_BASE   = 24'h000040;
  localparam int          FIFO_DEPTH = 4;
  localparam int          MAP_IDX    = 32'(HDR_BASE) + 'h15;
  localparam int          ROM_IDX    = 32'(HDR_BASE) + 'h17;
  localparam int          RAM_IDX    = 32'(HDR_BASE) + 'h18;

  logic        wclk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  din = 8'h00;
  logic        din_valid = 1'b0;
  logic        src_loading = 1'b0;
  logic [23:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_req;
  logic        mem_ack;
  logic [7:0]  map_ctrl;
  logic [3:0]  rom_size;
  logic [23:0] rom_mask;
  logic [23:0] ram_mask;
  logic        loading;
  logic        done;
  logic        overflow;

  always #5 wclk = ~wclk;

  rom_stream_writer #(
    .HDR_BASE   (HDR_BASE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .wclk        (wclk),
    .reset       (reset),
    .din         (din),
    .din_valid   (din_valid),
    .src_loading (src_loading),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .map_ctrl    (map_ctrl),
    .rom_size    (rom_size),
    .rom_mask    (rom_mask),
    .ram_mask    (ram_mask),
    .loading     (loading),
    .done        (done),
    .overflow    (overflow)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // 0: acknowledge after ack_delay cycles, 1: never, 2: stray ack every cycle
  int ack_mode = 1;
  int ack_delay = 0;

  logic [23:0] got_addr [$];
  logic [15:0] got_data [$];
  logic [7:0]  stim [$];
  logic [23:0] exp_addr [$];
  logic [15:0] exp_data [$];

  typedef struct {
    logic [7:0]  map_b;
    logic [7:0]  rom_b;
    logic [7:0]  ram_b;
    logic [7:0]  exp_map;
    logic [3:0]  exp_rom;
    logic [23:0] exp_rom_mask;
    logic [23:0] exp_ram_mask;
  } hdr_vec_t;

  hdr_vec_t vecs [5];

  // Memory-side responder: sole driver of mem_ack and the write log.
  initial begin : responder
    int wait_cnt;
    wait_cnt = 0;
    mem_ack = 1'b0;
    forever begin
      @(posedge wclk);
      #1;
      mem_ack = 1'b0;
      if (ack_mode == 2) begin
        mem_ack = 1'b1;
      end else if (ack_mode == 0 && mem_req && !reset) begin
        if (wait_cnt >= ack_delay) begin
          got_addr.push_back(mem_addr);
          got_data.push_back(mem_din);
          $display("[TB] write addr=%06h data=%04h", mem_addr, mem_din);
          mem_ack = 1'b1;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge wclk);
  endtask

  task automatic do_reset();
    @(negedge wclk);
    din_valid = 1'b0;
    src_loading = 1'b0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  // Called on a negedge; strobes one byte then idles gap cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    din = b;
    din_valid = 1'b1;
    @(negedge wclk);
    din_valid = 1'b0;
    tick(gap);
  endtask

  task automatic wait_finish(input string name);
    int n;
    n = 0;
    while (loading && n < 3000) begin
      @(negedge wclk);
      n++;
    end
    check({name, "_finish_timeout"}, 32'(loading), 32'd0);
  endtask

  task automatic run_stream(input int gmin, input int gmax);
    src_loading = 1'b1;
    foreach (stim[i]) send_byte(stim[i], int'($urandom_range(gmax, gmin)));
    src_loading = 1'b0;
  endtask

  // Reference: consecutive byte pairs form little-endian words at even
  // addresses; an odd trailing byte is padded with 0x00.
  task automatic build_model();
    exp_addr.delete();
    exp_data.delete();
    for (int k = 0; 2 * k < stim.size(); k++) begin
      exp_addr.push_back(24'(2 * k));
      if (2 * k + 1 < stim.size()) exp_data.push_back({stim[2 * k + 1], stim[2 * k]});
      else                         exp_data.push_back({8'h00, stim[2 * k]});
    end
  endtask

  task automatic compare_writes(input string name, input int base);
    check({name, "_nwrites"}, 32'(got_addr.size() - base), 32'(exp_addr.size()));
    for (int k = 0; k < exp_addr.size(); k++) begin
      if (base + k < got_addr.size()) begin
        check({name, "_addr"}, 32'(got_addr[base + k]), 32'(exp_addr[k]));
        check({name, "_data"}, 32'(got_data[base + k]), 32'(exp_data[k]));
      end
    end
  endtask

  function automatic logic [23:0] model_mask(input int code);
    longint unsigned m;
    m = (64'h400 << code) - 64'd1;
    return m[23:0];
  endfunction

  task automatic check_reset_values(input string name);
    check({name, "_mem_req"},  32'(mem_req),  32'd0);
    check({name, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({name, "_mem_din"},  32'(mem_din),  32'd0);
    check({name, "_map_ctrl"}, 32'(map_ctrl), 32'd0);
    check({name, "_rom_size"}, 32'(rom_size), 32'd0);
    check({name, "_rom_mask"}, 32'(rom_mask), 32'h3FF);
    check({name, "_ram_mask"}, 32'(ram_mask), 32'h3FF);
    check({name, "_loading"},  32'(loading),  32'd0);
    check({name, "_done"},     32'(done),     32'd0);
    check({name, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  initial begin : main
    int base;
    int len;
    int gmin;
    int gmax;
    logic [7:0] e_map;
    logic [7:0] e_rom;
    logic [7:0] e_ram;

    vecs[0] = '{8'h21, 8'h0A, 8'h03, 8'h21, 4'hA, 24'h0FFFFF, 24'h001FFF};
    vecs[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 24'h0003FF, 24'h0003FF};
    vecs[2] = '{8'h5C, 8'h0D, 8'h05, 8'h5C, 4'hD, 24'h7FFFFF, 24'h007FFF};
    vecs[3] = '{8'hFF, 8'h1E, 8'h0E, 8'hFF, 4'hE, 24'hFFFFFF, 24'hFFFFFF};
    vecs[4] = '{8'h80, 8'hF1, 8'hFF, 8'h80, 4'h1, 24'h0007FF, 24'hFFFFFF};

    // Reset state
    do_reset();
    check_reset_values("reset");

    // Eight bytes, 1 byte per 2 cycles, immediate acknowledge
    ack_mode = 0;
    ack_delay = 0;
    base = got_addr.size();
    stim = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    run_stream(1, 1);
    wait_finish("bytes8");
    exp_addr = '{24'h0, 24'h2, 24'h4, 24'h6};
    exp_data = '{16'h0100, 16'h0302, 16'h0504, 16'h0706};
    compare_writes("bytes8", base);
    check("bytes8_done", 32'(done), 32'd1);
    check("bytes8_overflow", 32'(overflow), 32'd0);

    // Bytes arriving in DONE are ignored
    base = got_addr.size();
    send_byte(8'h99, 1);
    send_byte(8'h98, 1);
    send_byte(8'h97, 1);
    tick(10);
    check("done_ignore_nwrites", 32'(got_addr.size() - base), 32'd0);
    check("done_ignore_done", 32'(done), 32'd1);
    check("done_ignore_req", 32'(mem_req), 32'd0);

    // Odd-length stream padded on flush
    do_reset();
    base = got_addr.size();
    stim = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    run_stream(1, 1);
    wait_finish("odd5");
    exp_addr = '{24'h0, 24'h2, 24'h4};
    exp_data = '{16'hBBAA, 16'hDDCC, 16'h00EE};
    compare_writes("odd5", base);
    check("odd5_done", 32'(done), 32'd1);

    // Header capture table
    for (int r = 0; r < 5; r++) begin
      do_reset();
      base = got_addr.size();
      stim.delete();
      for (int i = 0; i < 32'(HDR_BASE) + 'h19; i++) stim.push_back(8'(i) ^ 8'h5A);
      stim[MAP_IDX] = vecs[r].map_b;
      stim[ROM_IDX] = vecs[r].rom_b;
      stim[RAM_IDX] = vecs[r].ram_b;
      run_stream(1, 1);
      wait_finish("hdr");
      $display("[TB] header row %0d map=%02h rom=%0h rom_mask=%06h ram_mask=%06h",
               r, map_ctrl, rom_size, rom_mask, ram_mask);
      check("hdr_map_ctrl", 32'(map_ctrl), 32'(vecs[r].exp_map));
      check("hdr_rom_size", 32'(rom_size), 32'(vecs[r].exp_rom));
      check("hdr_rom_mask", 32'(rom_mask), 32'(vecs[r].exp_rom_mask));
      check("hdr_ram_mask", 32'(ram_mask), 32'(vecs[r].exp_ram_mask));
      build_model();
      compare_writes("hdr", base);
    end

    // Stalled memory: FIFO overflows, load still completes without done
    do_reset();
    base = got_addr.size();
    ack_mode = 1;
    stim.delete();
    for (int i = 0; i < 24; i++) stim.push_back(8'(i));
    src_loading = 1'b1;
    for (int i = 0; i < 20; i++) send_byte(stim[i], 1);
    ack_mode = 0;
    for (int i = 20; i < 24; i++) send_byte(stim[i], 1);
    src_loading = 1'b0;
    wait_finish("stall");
    check("stall_overflow", 32'(overflow), 32'd1);
    check("stall_done", 32'(done), 32'd0);
    check("stall_loading", 32'(loading), 32'd0);
    check("stall_dropped", 32'(got_addr.size() - base < 12), 32'd1);
    if (got_addr.size() > base) check("stall_first", 32'(got_data[base]), 32'h0100);

    // Asynchronous reset while a write is outstanding
    do_reset();
    ack_mode = 1;
    src_loading = 1'b1;
    send_byte(8'h11, 1);
    send_byte(8'h22, 1);
    send_byte(8'h33, 1);
    send_byte(8'h44, 1);
    check("arst_pre_req", 32'(mem_req), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("arst");
    src_loading = 1'b0;
    @(negedge wclk);
    reset = 1'b0;
    ack_mode = 2;
    tick(3);
    ack_mode = 1;
    tick(1);
    check("arst_stray_ack_req", 32'(mem_req), 32'd0);
    check("arst_stray_ack_addr", 32'(mem_addr), 32'd0);
    ack_mode = 0;
    base = got_addr.size();
    stim = '{8'h55, 8'h66, 8'h77, 8'h88};
    run_stream(1, 1);
    wait_finish("arst_after");
    exp_addr = '{24'h0, 24'h2};
    exp_data = '{16'h6655, 16'h8877};
    compare_writes("arst_after", base);
    check("arst_after_done", 32'(done), 32'd1);

    // Push coinciding with pop while the FIFO is full
    do_reset();
    base = got_addr.size();
    ack_mode = 1;
    ack_delay = 0;
    stim.delete();
    for (int i = 0; i < 12; i++) stim.push_back(8'(i));
    src_loading = 1'b1;
    for (int i = 0; i < 11; i++) send_byte(stim[i], 1);
    ack_mode = 0;             // acknowledge the held word once
    @(negedge wclk);
    @(negedge wclk);          // mem_req is low now; the pop happens next edge
    ack_mode = 1;
    din = stim[11];
    din_valid = 1'b1;         // completes a word on that same edge
    @(negedge wclk);
    din_valid = 1'b0;
    check("fullpp_req", 32'(mem_req), 32'd1);
    check("fullpp_overflow", 32'(overflow), 32'd0);
    ack_mode = 0;
    src_loading = 1'b0;
    wait_finish("fullpp");
    build_model();
    compare_writes("fullpp", base);
    check("fullpp_done", 32'(done), 32'd1);
    check("fullpp_overflow_end", 32'(overflow), 32'd0);

    // Randomised streams against the reference model
    for (int t = 0; t < 8; t++) begin
      do_reset();
      base = got_addr.size();
      ack_mode = 0;
      ack_delay = int'($urandom_range(1, 0));
      gmin = (ack_delay == 0) ? 1 : 2;
      gmax = gmin + 2;
      len = int'($urandom_range(110, 1));
      stim.delete();
      for (int i = 0; i < len; i++) stim.push_back(8'($urandom_range(255, 0)));
      run_stream(gmin, gmax);
      wait_finish("rand");
      $display("[TB] random stream %0d len=%0d ack_delay=%0d", t, len, ack_delay);
      build_model();
      compare_writes("rand", base);
      e_map = (len > MAP_IDX) ? stim[MAP_IDX] : 8'h00;
      e_rom = (len > ROM_IDX) ? stim[ROM_IDX] : 8'h00;
      e_ram = (len > RAM_IDX) ? stim[RAM_IDX] : 8'h00;
      check("rand_map_ctrl", 32'(map_ctrl), 32'(e_map));
      check("rand_rom_size", 32'(rom_size), 32'(e_rom % 16));
      check("rand_rom_mask", 32'(rom_mask), 32'(model_mask(int'(e_rom % 16))));
      check("rand_ram_mask", 32'(ram_mask), 32'(model_mask(int'(e_ram))));
      check("rand_done", 32'(done), 32'd1);
      check("rand_overflow", 32'(overflow), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rom_stream_writer.md
ROM_STREAM_WRITER -- requirements
Module: rom_stream_writer

Interface
REQ-001 Parameter HDR_BASE, default 24'h007FC0, stream byte offset of the cartridge header.
REQ-002 Parameter FIFO_DEPTH, default 4, word-FIFO entries (power of two, 2..16).
REQ-003 wclk  in  1  sole clock; all logic on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 din  in  8  stream byte from ROM loader.
REQ-006 din_valid  in  1  one-cycle strobe qualifying din; no back-pressure path to source.
REQ-007 src_loading  in  1  high while source still has bytes to send.
REQ-008 mem_addr  out  24  byte address of even byte being written (bit 0 always 0).
REQ-009 mem_din  out  16  write data, low byte = even address.
REQ-010 mem_req  out  1  write request, held until mem_ack.
REQ-011 mem_ack  in  1  one-cycle acknowledge, completes current write.
REQ-012 map_ctrl  out  8; rom_size  out  4; rom_mask  out  24; ram_mask  out  24  captured header values.
REQ-013 loading  out  1  high from first byte until all words written.
REQ-014 done  out  1  high after successful completion until reset.
REQ-015 overflow  out  1  sticky: byte arrived with FIFO full.

Function
REQ-016 FSM states IDLE, LOAD, FLUSH, DONE; reset enters IDLE.
REQ-017 IDLE->LOAD on first din_valid or src_loading=1; LOAD->FLUSH when src_loading falls; FLUSH->DONE when FIFO empty, no pending half-word, mem_req low; DONE terminal until reset.
REQ-018 Byte counter (24 bit) increments once per din_valid, starts at 0, wraps at 2^24 silently.
REQ-019 Even-offset byte latched as low half; odd-offset byte completes word {din, low} and pushes FIFO with address count-1 in same cycle.
REQ-020 On entering FLUSH with pending low half, push word {8'h00, low} once.
REQ-021 Writer pops FIFO head into mem_addr/mem_din and raises mem_req the cycle after head valid; mem_req drops the cycle after mem_ack; next pop no earlier than that cycle.
REQ-022 mem_ack while mem_req low is ignored.
REQ-023 Push and pop in same cycle permitted at any occupancy, including full (occupancy unchanged).
REQ-024 Push with FIFO full and no simultaneous pop: word dropped, overflow set, load continues.
REQ-025 Header capture: byte at HDR_BASE+0x15 -> map_ctrl; HDR_BASE+0x17 -> rom_size (bits 3:0); HDR_BASE+0x18 -> internal ram_size (8 bit).
REQ-026 rom_mask = (24'h400 << rom_size) - 1; ram_mask = (24'h400 << ram_size) - 1, truncated to 24 bits; registered, valid cycle after capture.
REQ-027 loading = state is LOAD or FLUSH; done = state is DONE and overflow low.
REQ-028 din_valid in DONE ignored (no counter change, no push).

Reset
REQ-029 Reset values: mem_req 0, mem_addr 0, mem_din 0, map_ctrl 0, rom_size 0, rom_mask 24'h0003FF, ram_mask 24'h0003FF, loading 0, done 0, overflow 0, FIFO empty, counter 0.
REQ-030 Reset asserted mid-transfer drops mem_req immediately (asynchronously); a later mem_ack is ignored.

Structure
REQ-031 Shared package holds state enum and header offset constants (0x15, 0x17, 0x18) and mask base 24'h400.
REQ-032 Word FIFO is sub-module rom_word_fifo (40-bit entries: 24 addr + 16 data, full/empty, simultaneous push/pop).

Verification
REQ-033 Stream 8 bytes 00..07 at 1 byte/2 cycles, mem_ack 1 cycle after mem_req -> writes (0,0x0100),(2,0x0302),(4,0x0504),(6,0x0706); done=1.
REQ-034 Stream 5 bytes AA,BB,CC,DD,EE then drop src_loading -> final write addr 4 data 0x00EE, then DONE.
REQ-035 Header bytes 0x21 at 0x7FD5, 0x0A at 0x7FD7, 0x03 at 0x7FD8 -> map_ctrl 0x21, rom_size 0xA, rom_mask 0x0FFFFF, ram_mask 0x001FFF.
REQ-036 Hold mem_ack low for 40 cycles during 1-byte/2-cycle stream, FIFO_DEPTH 4 -> overflow=1, done stays 0 at end, loading falls.
REQ-037 Assert reset while mem_req high -> mem_req low same cycle, all outputs at REQ-029 values; subsequent 4-byte stream writes from address 0.
REQ-038 Pop and push coincide with FIFO full -> no overflow, occupancy stays FIFO_DEPTH.
